// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
// The IR fields, flags and ready inputs flow into the controller; enables, selects and debug state flow out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       imem_rdy;
    logic       dmem_rdy;

    logic       PCWr;
    logic [1:0] NPCOp;
    logic       IRWr;
    logic       RFWr;
    logic       DMWr;
    logic       DMRd;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic [1:0] EXTOp;
    logic [1:0] WRSel;
    logic [1:0] WDSel;
    logic       illegal;
    logic [3:0] state;

    // Datapath / stimulus side
    modport master (
        output op, funct, zero, imem_rdy, dmem_rdy,
        input  PCWr, NPCOp, IRWr, RFWr, DMWr, DMRd, ALUSrc, ALUOp,
               EXTOp, WRSel, WDSel, illegal, state
    );

    // Controller side
    modport slave (
        input  op, funct, zero, imem_rdy, dmem_rdy,
        output PCWr, NPCOp, IRWr, RFWr, DMWr, DMRd, ALUSrc, ALUOp,
               EXTOp, WRSel, WDSel, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and write-back, with wait-states on both memories.
module mc_ctrl #(
    parameter int              ST_W        = 4,
    parameter logic [ST_W-1:0] RESET_STATE = '0
) (
    input logic       clk,
    input logic       rst,
    mc_ctrl_if.slave  ctl
);

    typedef enum logic [ST_W-1:0] {
        FETCH = 'd0,
        DCD   = 'd1,
        MA    = 'd2,
        MR    = 'd3,
        MWB   = 'd4,
        MW    = 'd5,
        EXE   = 'd6,
        AWB   = 'd7,
        BR    = 'd8,
        JMP   = 'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_REG  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_FN   = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;

    localparam logic [1:0] WR_RT    = 2'b00;
    localparam logic [1:0] WR_RD    = 2'b01;
    localparam logic [1:0] WR_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    state_e state_q;
    state_e state_d;

    // Instruction decode from the IR fields
    logic is_rtype_op;
    logic is_r_alu;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;

    always_comb begin
        is_rtype_op = (ctl.op == OP_RTYPE);
        is_r_alu    = 1'b0;
        is_jr       = 1'b0;
        if (is_rtype_op) begin
            case (ctl.funct)
                FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: is_r_alu = 1'b1;
                FN_JR:                                   is_jr    = 1'b1;
                default: ;
            endcase
        end
        is_ori = (ctl.op == OP_ORI);
        is_lui = (ctl.op == OP_LUI);
        is_lw  = (ctl.op == OP_LW);
        is_sw  = (ctl.op == OP_SW);
        is_beq = (ctl.op == OP_BEQ);
        is_j   = (ctl.op == OP_J);
        is_jal = (ctl.op == OP_JAL);
    end

    // ALU setup shared by EXE and AWB so the result stays stable through write-back
    logic       exe_alu_src;
    logic [1:0] exe_alu_op;
    logic [1:0] exe_ext_op;

    always_comb begin
        exe_alu_src = 1'b0;
        exe_alu_op  = ALU_ADD;
        exe_ext_op  = EXT_ZERO;
        if (is_rtype_op) begin
            exe_alu_op  = ALU_FN;
        end else if (is_ori) begin
            exe_alu_src = 1'b1;
            exe_ext_op  = EXT_ZERO;
            exe_alu_op  = ALU_OR;
        end else if (is_lui) begin
            exe_alu_src = 1'b1;
            exe_ext_op  = EXT_HI;
            exe_alu_op  = ALU_ADD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    logic       pc_wr;
    logic [1:0] npc_op;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic       dm_rd;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
    logic [1:0] wr_sel;
    logic [1:0] wd_sel;
    logic       illegal;

    always_comb begin
        state_d = state_q;
        pc_wr   = 1'b0;
        npc_op  = NPC_PC4;
        ir_wr   = 1'b0;
        rf_wr   = 1'b0;
        dm_wr   = 1'b0;
        dm_rd   = 1'b0;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        ext_op  = EXT_ZERO;
        wr_sel  = WR_RT;
        wd_sel  = WD_ALU;
        illegal = 1'b0;

        case (state_q)
            FETCH: begin
                ir_wr  = ctl.imem_rdy;
                pc_wr  = ctl.imem_rdy;
                npc_op = NPC_PC4;
                if (ctl.imem_rdy) state_d = DCD;
            end

            DCD: begin
                if (is_lw || is_sw) begin
                    state_d = MA;
                end else if (is_r_alu || is_ori || is_lui) begin
                    state_d = EXE;
                end else if (is_beq) begin
                    state_d = BR;
                end else if (is_j || is_jal || is_jr) begin
                    state_d = JMP;
                end else begin
                    state_d = FETCH;
                    illegal = 1'b1;
                end
            end

            MA: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                alu_op  = ALU_ADD;
                if (is_lw)      state_d = MR;
                else if (is_sw) state_d = MW;
                else            state_d = FETCH;
            end

            MR: begin
                dm_rd   = 1'b1;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                alu_op  = ALU_ADD;
                if (ctl.dmem_rdy) state_d = MWB;
            end

            MWB: begin
                rf_wr   = 1'b1;
                wr_sel  = WR_RT;
                wd_sel  = WD_MEM;
                state_d = FETCH;
            end

            // The write strobe is held until the memory accepts it
            MW: begin
                dm_wr   = 1'b1;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                alu_op  = ALU_ADD;
                if (ctl.dmem_rdy) state_d = FETCH;
            end

            EXE: begin
                alu_src = exe_alu_src;
                alu_op  = exe_alu_op;
                ext_op  = exe_ext_op;
                state_d = AWB;
            end

            AWB: begin
                alu_src = exe_alu_src;
                alu_op  = exe_alu_op;
                ext_op  = exe_ext_op;
                rf_wr   = 1'b1;
                wd_sel  = WD_ALU;
                wr_sel  = is_rtype_op ? WR_RD : WR_RT;
                state_d = FETCH;
            end

            BR: begin
                alu_src = 1'b0;
                alu_op  = ALU_SUB;
                ext_op  = EXT_SIGN;
                npc_op  = NPC_BR;
                pc_wr   = ctl.zero;
                state_d = FETCH;
            end

            // PC already holds PC+4 here, which is what jal links into $31
            JMP: begin
                pc_wr = 1'b1;
                if (is_jr) begin
                    npc_op = NPC_REG;
                end else begin
                    npc_op = NPC_JMP;
                end
                if (is_jal) begin
                    rf_wr  = 1'b1;
                    wr_sel = WR_RA;
                    wd_sel = WD_PC;
                end
                state_d = FETCH;
            end

            default: state_d = FETCH;
        endcase
    end

    // Write enables are masked while reset is held so nothing commits mid-instruction
    assign ctl.PCWr    = pc_wr   & ~rst;
    assign ctl.IRWr    = ir_wr   & ~rst;
    assign ctl.RFWr    = rf_wr   & ~rst;
    assign ctl.DMWr    = dm_wr   & ~rst;
    assign ctl.DMRd    = dm_rd   & ~rst;
    assign ctl.illegal = illegal & ~rst;
    assign ctl.NPCOp   = npc_op;
    assign ctl.ALUSrc  = alu_src;
    assign ctl.ALUOp   = alu_op;
    assign ctl.EXTOp   = ext_op;
    assign ctl.WRSel   = wr_sel;
    assign ctl.WDSel   = wd_sel;
    assign ctl.state   = 4'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is expanded into its expected
// cycle-by-cycle micro-sequence and compared against the controller outputs.
module tb_mc_ctrl;

    logic clk;
    logic rst;

    mc_ctrl_if cif ();

    mc_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .ctl (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_R   = 0;
    localparam int K_JR  = 1;
    localparam int K_ORI = 2;
    localparam int K_LUI = 3;
    localparam int K_LW  = 4;
    localparam int K_SW  = 5;
    localparam int K_BEQ = 6;
    localparam int K_J   = 7;
    localparam int K_JAL = 8;
    localparam int K_ILL = 9;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] out;
        logic        imem;
        logic        dmem;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  funct;
    } cyc_t;

    cyc_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int n_instr  = 0;

    logic [5:0] prev_op    = 6'd0;
    logic [5:0] prev_funct = 6'd0;
    logic [5:0] cur_op;
    logic [5:0] cur_funct;

    logic [16:0] obs;
    assign obs = {cif.PCWr, cif.NPCOp, cif.IRWr, cif.RFWr, cif.DMWr, cif.DMRd,
                  cif.ALUSrc, cif.ALUOp, cif.EXTOp, cif.WRSel, cif.WDSel, cif.illegal};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic pcwr, input logic [1:0] npc,
                                       input logic irwr, input logic rfwr, input logic dmwr,
                                       input logic dmrd, input logic alusrc,
                                       input logic [1:0] aluop, input logic [1:0] extop,
                                       input logic [1:0] wrsel, input logic [1:0] wdsel,
                                       input logic ill);
        return {pcwr, npc, irwr, rfwr, dmwr, dmrd, alusrc, aluop, extop, wrsel, wdsel, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010: return K_R;
                    6'b001000: return K_JR;
                    default:   return K_ILL;
                endcase
            end
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input logic [16:0] out,
                        input logic imem, input logic dmem, input logic zero,
                        input logic [5:0] op, input logic [5:0] funct);
        cyc_t c;
        c.st = st; c.out = out; c.imem = imem; c.dmem = dmem; c.zero = zero;
        c.op = op; c.funct = funct;
        exp_q.push_back(c);
    endtask

    // Expand one instruction into the cycles it should take
    task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic zero_br,
                         input int wi, input int wd);
        int k;
        logic [16:0] memc;
        logic [16:0] exec;
        for (int i = 0; i < wi; i++)
            push(4'd0, 17'd0, 1'b0, rb(), rb(), prev_op, prev_funct);
        push(4'd0, mk(1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
             1'b1, rb(), rb(), prev_op, prev_funct);
        prev_op    = op;
        prev_funct = funct;
        k = classify(op, funct);
        push(4'd1, mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, k == K_ILL),
             rb(), rb(), rb(), op, funct);
        memc = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
        case (k)
            K_LW: begin
                push(4'd2, memc, rb(), rb(), rb(), op, funct);
                for (int i = 0; i < wd; i++)
                    push(4'd3, memc | mk(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                         rb(), 1'b0, rb(), op, funct);
                push(4'd3, memc | mk(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                     rb(), 1'b1, rb(), op, funct);
                push(4'd4, mk(0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0),
                     rb(), rb(), rb(), op, funct);
            end
            K_SW: begin
                push(4'd2, memc, rb(), rb(), rb(), op, funct);
                for (int i = 0; i < wd; i++)
                    push(4'd5, memc | mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                         rb(), 1'b0, rb(), op, funct);
                push(4'd5, memc | mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                     rb(), 1'b1, rb(), op, funct);
            end
            K_R, K_ORI, K_LUI: begin
                if (k == K_R)        exec = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
                else if (k == K_ORI) exec = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0);
                else                 exec = mk(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 2'b00, 0);
                push(4'd6, exec, rb(), rb(), rb(), op, funct);
                push(4'd7, exec | mk(0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00,
                                     (k == K_R) ? 2'b01 : 2'b00, 2'b00, 0),
                     rb(), rb(), rb(), op, funct);
            end
            K_BEQ:
                push(4'd8, mk(zero_br, 2'b01, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0),
                     rb(), rb(), zero_br, op, funct);
            K_J:
                push(4'd9, mk(1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                     rb(), rb(), rb(), op, funct);
            K_JAL:
                push(4'd9, mk(1, 2'b10, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 0),
                     rb(), rb(), rb(), op, funct);
            K_JR:
                push(4'd9, mk(1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                     rb(), rb(), rb(), op, funct);
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1; outputs checked on the falling edge
    task automatic run_q(input int limit);
        cyc_t c;
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            c = exp_q.pop_front();
            cif.op       = c.op;
            cif.funct    = c.funct;
            cif.imem_rdy = c.imem;
            cif.dmem_rdy = c.dmem;
            cif.zero     = c.zero;
            @(negedge clk);
            check_val($sformatf("i%0d_c%0d_state", n_instr, n), 32'(cif.state), 32'(c.st));
            check_val($sformatf("i%0d_c%0d_ctl", n_instr, n), 32'(obs), 32'(c.out));
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero_br,
                            input int wi, input int wd);
        int ncyc;
        build(op, funct, zero_br, wi, wd);
        ncyc = exp_q.size();
        run_q(1000);
        $display("instr %0d op=%b funct=%b zero=%0d wi=%0d wd=%0d cycles=%0d",
                 n_instr, op, funct, zero_br, wi, wd, ncyc);
        n_instr++;
    endtask

    task automatic rand_instr(output logic [5:0] op, output logic [5:0] funct);
        int r;
        r = $urandom_range(0, 13);
        funct = 6'($urandom);
        case (r)
            0: begin op = 6'b000000; funct = 6'b100001; end
            1: begin op = 6'b000000; funct = 6'b100011; end
            2: begin op = 6'b000000; funct = 6'b100100; end
            3: begin op = 6'b000000; funct = 6'b100101; end
            4: begin op = 6'b000000; funct = 6'b101010; end
            5: begin op = 6'b000000; funct = 6'b001000; end
            6: op = 6'b001101;
            7: op = 6'b001111;
            8: op = 6'b100011;
            9: op = 6'b101011;
            10: op = 6'b000100;
            11: op = 6'b000010;
            12: op = 6'b000011;
            default: begin
                op = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'($urandom);
                while (classify(op, funct) != K_ILL) begin
                    funct = 6'($urandom);
                    if (op != 6'b000000) op = 6'($urandom);
                end
            end
        endcase
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] funct;

        rst          = 1'b1;
        cif.op       = 6'd0;
        cif.funct    = 6'd0;
        cif.zero     = 1'b0;
        cif.imem_rdy = 1'b1;
        cif.dmem_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("por_state", 32'(cif.state), 32'd0);
        check_val("por_ctl", 32'(obs), 32'd0);
        rst = 1'b0;

        // Directed cases
        do_instr(6'b100011, 6'd0, 1'b0, 0, 2);           // lw, two data waits
        do_instr(6'b101011, 6'd0, 1'b0, 0, 0);           // sw
        do_instr(6'b000100, 6'd0, 1'b1, 0, 0);           // beq taken
        do_instr(6'b000100, 6'd0, 1'b0, 1, 0);           // beq not taken
        do_instr(6'b000011, 6'd0, 1'b0, 0, 0);           // jal
        do_instr(6'b000000, 6'b001000, 1'b0, 0, 0);      // jr
        do_instr(6'b111111, 6'd0, 1'b0, 0, 0);           // illegal opcode
        do_instr(6'b000000, 6'b100001, 1'b0, 2, 0);      // addu
        do_instr(6'b001111, 6'd0, 1'b0, 0, 0);           // lui

        // Reset while a load waits in MR
        build(6'b100011, 6'd0, 1'b0, 0, 3);
        run_q(4);
        check_val("pre_rst_state", 32'(cif.state), 32'd3);
        exp_q.delete();
        cif.imem_rdy = 1'b1;
        cif.dmem_rdy = 1'b1;
        rst = 1'b1;
        #1;
        check_val("rst_state", 32'(cif.state), 32'd0);
        check_val("rst_ctl", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check_val("rst_hold_ctl", 32'(obs), 32'd0);
        rst = 1'b0;
        $display("reset applied during MR");
        do_instr(6'b000000, 6'b101010, 1'b0, 0, 0);      // first fetch right after reset

        for (int t = 0; t < 250; t++) begin
            rand_instr(op, funct);
            do_instr(op, funct, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS-subset CPU.
- Sequences the PC register, instruction register, register file, ALU and data memory over 3–5 cycles per instruction.
- Generates the PC write enable (PCWr) and next-PC select (NPCOp) that drive the PC/NPC datapath.
- Supports wait-states from instruction and data memories through ready handshakes.

Parameters:
- ST_W, 4, state register width.
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op  input  6  instr[31:26] from IR.
- funct  input  6  instr[5:0] from IR.
- zero  input  1  ALU zero flag (rs == rt for beq).
- imem_rdy  input  1  instruction memory data valid this cycle.
- dmem_rdy  input  1  data memory read data valid / write accepted this cycle.
- PCWr  output  1  PC load enable.
- NPCOp  output  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
- IRWr  output  1  instruction register load enable.
- RFWr  output  1  register file write enable.
- DMWr  output  1  data memory write strobe.
- DMRd  output  1  data memory read request.
- ALUSrc  output  1  0 = rt, 1 = extended immediate.
- ALUOp  output  2  00 add, 01 sub, 10 or, 11 decode funct.
- EXTOp  output  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- WRSel  output  2  00 rt, 01 rd, 10 $31.
- WDSel  output  2  00 ALU result, 01 memory data, 10 PC.
- illegal  output  1  one-cycle pulse on unsupported opcode/funct.
- state  output  4  current state (debug/verification).

Behaviour:
- States: FETCH=0, DCD=1, MA=2, MR=3, MWB=4, MW=5, EXE=6, AWB=7, BR=8, JMP=9. Codes 10–15 go to FETCH on the next edge with no writes.
- Supported instructions:
  - R-type (op=000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000.
  - I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Outputs are combinational from state, op, funct, zero, imem_rdy and dmem_rdy. Defaults: all enables 0, all selects 0.
- FETCH: IRWr=PCWr=imem_rdy, NPCOp=00.
  - imem_rdy=0: stay in FETCH.
  - imem_rdy=1: go to DCD.
- DCD: no writes. Decode:
  - lw/sw → MA.
  - R-type non-jr, ori, lui → EXE.
  - beq → BR.
  - j, jal, jr → JMP.
  - Anything else → FETCH with illegal=1 for this cycle only.
- MA: ALUSrc=1, EXTOp=01, ALUOp=00. lw → MR, sw → MW.
- MR: DMRd=1, ALU controls held as in MA.
  - dmem_rdy=0: stay in MR.
  - dmem_rdy=1: go to MWB.
- MWB: RFWr=1, WRSel=00, WDSel=01 → FETCH.
- MW: DMWr=1, ALU controls held as in MA.
  - dmem_rdy=0: stay in MW; the strobe stays high until accepted.
  - dmem_rdy=1: go to FETCH.
- EXE:
  - R-type: ALUSrc=0, ALUOp=11.
  - ori: ALUSrc=1, EXTOp=00, ALUOp=10.
  - lui: ALUSrc=1, EXTOp=10, ALUOp=00.
  - Next state AWB.
- AWB: RFWr=1, WDSel=00, WRSel=01 for R-type else 00, EXE ALU controls held → FETCH.
- BR: ALUSrc=0, ALUOp=01, EXTOp=01, NPCOp=01, PCWr=zero → FETCH.
- JMP: PCWr=1 → FETCH.
  - j: NPCOp=10.
  - jal: NPCOp=10, plus RFWr=1, WRSel=10, WDSel=10. The PC value already holds PC+4 and is written to $31 on the same edge the PC loads the target.
  - jr: NPCOp=11.
- Instruction cost in cycles, zero wait states: lw 5, sw 4, R/ori/lui 4, beq 3, j/jal/jr 3. Each memory wait cycle adds exactly 1.
- Reset:
  - rst high immediately forces state=FETCH.
  - While rst is high, PCWr, IRWr, RFWr, DMWr, DMRd and illegal are forced 0.
  - Reset in the middle of an instruction abandons it; no partial register file or memory write occurs after rst rises.
  - After rst falls, the first fetch begins at the next edge at which imem_rdy=1.
- Simultaneous events: zero is sampled only in BR; ready inputs are ignored outside FETCH, MR and MW.

Test Plan:
- Reset: rst=1 during MR → state=0 at once; RFWr and DMRd 0. Release rst with imem_rdy=1 → IRWr=PCWr=1 in the first cycle, NPCOp=00.
- lw with dmem_rdy low for 2 cycles: state sequence 0,1,2,3,3,3,4,0. RFWr=1 only in state 4 with WDSel=01 and WRSel=00; 7 cycles total.
- sw with imem_rdy=1 and dmem_rdy=1: states 0,1,2,5,0. DMWr is high for exactly 1 cycle; RFWr is never asserted.
- beq, zero=1 then zero=0: PCWr=1 with NPCOp=01 in state 8 for the first, PCWr=0 for the second; 3 cycles each.
- jal: in state 9, PCWr=1, NPCOp=10, RFWr=1, WRSel=10, WDSel=10 all in the same cycle. jr (op 0, funct 001000) → NPCOp=11 with RFWr=0.
- op=111111: states 0,1,0; illegal pulses high for 1 cycle in state 1; no enable is asserted apart from the fetch.
